// File: rtl/ts_ref_pkg.sv
// Shared constants for the reference timestamp and its readout logic.
package ts_ref_pkg;

  localparam int unsigned DEF_WIDTH     = 64;
  localparam int unsigned DEF_SEG_WIDTH = 32;
  localparam int unsigned DEF_N_CH      = 4;

  function automatic int unsigned nseg(input int unsigned width, input int unsigned seg_width);
    return width / seg_width;
  endfunction

endpackage

// File: rtl/ts_ref_multi_if.sv
// Capture bus between the timestamp block (slave) and trigger/readout logic (master).
interface ts_ref_multi_if
  import ts_ref_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned N_CH  = DEF_N_CH
);

  logic [N_CH-1:0]       trig;
  logic [N_CH-1:0]       cap_ack;
  logic [N_CH-1:0]       cap_valid;
  logic [N_CH*WIDTH-1:0] cap_data;
  logic [N_CH-1:0]       overrun;

  modport master (
    output trig, cap_ack,
    input  cap_valid, cap_data, overrun
  );

  modport slave (
    input  trig, cap_ack,
    output cap_valid, cap_data, overrun
  );

endinterface

// File: rtl/ts_seg_counter.sv
// Segmented tick counter; a segment wrap increments the next segment one cycle later.
module ts_seg_counter
  import ts_ref_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned SEG_WIDTH = DEF_SEG_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             settled
);

  localparam int unsigned NSEG = nseg(WIDTH, SEG_WIDTH);

  logic [NSEG-1:0][SEG_WIDTH-1:0] seg;
  // pend[k] = carry waiting to enter segment k; pend[0] is never set
  logic [NSEG-1:0]                pend;
  logic [NSEG-1:0]                inc;

  always_comb begin
    inc    = pend;
    inc[0] = tick;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg  <= '0;
      pend <= '0;
    end else if (load) begin
      seg  <= load_value;
      pend <= '0;
    end else begin
      pend[0] <= 1'b0;
      for (int unsigned k = 0; k < NSEG; k++) begin
        seg[k] <= seg[k] + SEG_WIDTH'(inc[k]);
      end
      for (int unsigned k = 1; k < NSEG; k++) begin
        pend[k] <= inc[k-1] && (seg[k-1] == '1);
      end
    end
  end

  assign count   = seg;
  assign settled = ~|pend;

endmodule

// File: rtl/ts_ref_multi.sv
// Tick-counting reference timestamp with N_CH coherent capture channels.
module ts_ref_multi
  import ts_ref_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned SEG_WIDTH = DEF_SEG_WIDTH,
  parameter int unsigned N_CH      = DEF_N_CH
) (
  input  logic             sampling_clk,
  input  logic             reset_falling,
  input  logic             clk_in_rising,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] ref_value,
  output logic             ref_valid,
  output logic             tick_err,
  ts_ref_multi_if.slave    cap
);

  logic [WIDTH-1:0]      count;
  logic                  settled;
  logic                  tick_eff;
  logic [N_CH-1:0]       held;
  logic [N_CH-1:0]       req;
  logic [N_CH-1:0]       cap_now;
  logic [N_CH-1:0]       valid_q;
  logic [N_CH-1:0]       overrun_q;
  logic [N_CH*WIDTH-1:0] data_q;

  assign tick_eff = clk_in_rising & ~load;
  assign req      = cap.trig | held;
  assign cap_now  = req & {N_CH{settled}};

  ts_seg_counter #(
    .WIDTH     (WIDTH),
    .SEG_WIDTH (SEG_WIDTH)
  ) u_cnt (
    .clk        (sampling_clk),
    .rst        (reset_falling),
    .load       (load),
    .load_value (load_value),
    .tick       (tick_eff),
    .count      (count),
    .settled    (settled)
  );

  always_ff @(posedge sampling_clk) begin
    if (reset_falling) begin
      ref_value <= '0;
      ref_valid <= 1'b0;
      tick_err  <= 1'b0;
      held      <= '0;
      valid_q   <= '0;
      overrun_q <= '0;
      data_q    <= '0;
    end else begin
      ref_valid <= tick_eff;
      if (tick_eff) ref_value <= count;
      if (tick_eff && !settled) tick_err <= 1'b1;
      for (int unsigned i = 0; i < N_CH; i++) begin
        // one-deep hold: repeated trigs while unsettled merge into one request
        held[i] <= req[i] & ~settled;
        if (cap_now[i]) begin
          if (!valid_q[i] || cap.cap_ack[i]) begin
            data_q[i*WIDTH +: WIDTH] <= count;
            valid_q[i]               <= 1'b1;
          end else begin
            overrun_q[i] <= 1'b1;
          end
        end else if (cap.cap_ack[i]) begin
          valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign cap.cap_valid = valid_q;
  assign cap.cap_data  = data_q;
  assign cap.overrun   = overrun_q;

endmodule

// File: tb/tb_ts_ref_multi.sv
// Directed bench for ts_ref_multi with WIDTH=16, SEG_WIDTH=8, N_CH=2.
module tb_ts_ref_multi;

  logic        sampling_clk = 1'b0;
  logic        reset_falling;
  logic        clk_in_rising;
  logic        load;
  logic [15:0] load_value;
  logic [15:0] ref_value;
  logic        ref_valid;
  logic        tick_err;
  int          n_assert = 0;
  int          n_fail   = 0;

  ts_ref_multi_if #(.WIDTH(16), .N_CH(2)) cap_bus ();

  ts_ref_multi #(
    .WIDTH     (16),
    .SEG_WIDTH (8),
    .N_CH      (2)
  ) dut (
    .sampling_clk  (sampling_clk),
    .reset_falling (reset_falling),
    .clk_in_rising (clk_in_rising),
    .load          (load),
    .load_value    (load_value),
    .ref_value     (ref_value),
    .ref_valid     (ref_valid),
    .tick_err      (tick_err),
    .cap           (cap_bus)
  );

  always #5 sampling_clk = ~sampling_clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sampling_clk);
    #1;
  endtask

  task automatic do_tick();
    clk_in_rising = 1'b1;
    cyc();
    clk_in_rising = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] v);
    load       = 1'b1;
    load_value = v;
    cyc();
    load       = 1'b0;
  endtask

  initial begin
    reset_falling   = 1'b1;
    clk_in_rising   = 1'b0;
    load            = 1'b0;
    load_value      = '0;
    cap_bus.trig    = '0;
    cap_bus.cap_ack = '0;
    cyc();
    cyc();
    chk("rst_ref", ref_value, 16'h0000);
    chk("rst_ref_valid", ref_valid, 1'b0);
    chk("rst_cap_valid", cap_bus.cap_valid, 2'b00);
    chk("rst_cap_data", cap_bus.cap_data, 32'h0);
    chk("rst_overrun", cap_bus.overrun, 2'b00);
    chk("rst_tick_err", tick_err, 1'b0);
    reset_falling = 1'b0;
    cyc();

    // 1. three ticks spaced 4 cycles
    for (int k = 0; k < 3; k++) begin
      do_tick();
      chk("t1_ref", ref_value, 64'(k));
      chk("t1_ref_valid_hi", ref_valid, 1'b1);
      cyc();
      chk("t1_ref_valid_lo", ref_valid, 1'b0);
      cyc();
      cyc();
    end
    cap_bus.trig = 2'b01;
    cyc();
    cap_bus.trig = 2'b00;
    chk("t1_cap_valid", cap_bus.cap_valid, 2'b01);
    chk("t1_count3", cap_bus.cap_data[15:0], 16'h0003);
    chk("t1_tick_err", tick_err, 1'b0);
    chk("t1_overrun", cap_bus.overrun, 2'b00);
    cap_bus.cap_ack = 2'b01;
    cyc();
    cap_bus.cap_ack = 2'b00;
    chk("t1_ack_clears", cap_bus.cap_valid, 2'b00);

    // 2. carry into the high segment
    do_load(16'h00FF);
    do_tick();
    chk("t2_ref", ref_value, 16'h00FF);
    chk("t2_count_low_wrapped", dut.count, 16'h0000);
    cyc();
    chk("t2_count_settled", dut.count, 16'h0100);

    // 3. trig during pending carry is delayed one cycle
    do_load(16'h00FF);
    do_tick();
    cap_bus.trig = 2'b01;
    cyc();
    cap_bus.trig = 2'b00;
    chk("t3_held_not_valid", cap_bus.cap_valid, 2'b00);
    cyc();
    chk("t3_cap_valid", cap_bus.cap_valid, 2'b01);
    chk("t3_cap_data0", cap_bus.cap_data[15:0], 16'h0100);

    // 4. overrun and capture-with-ack on channel 1
    cap_bus.trig = 2'b10;
    cyc();
    cap_bus.trig = 2'b00;
    chk("t4_first_cap", cap_bus.cap_data[31:16], 16'h0100);
    chk("t4_ovr_clear", cap_bus.overrun, 2'b00);
    do_load(16'h1234);
    cap_bus.trig = 2'b10;
    cyc();
    cap_bus.trig = 2'b00;
    chk("t4_data_kept", cap_bus.cap_data[31:16], 16'h0100);
    chk("t4_overrun", cap_bus.overrun, 2'b10);
    cap_bus.trig    = 2'b10;
    cap_bus.cap_ack = 2'b10;
    cyc();
    cap_bus.trig    = 2'b00;
    cap_bus.cap_ack = 2'b00;
    chk("t4_new_data", cap_bus.cap_data[31:16], 16'h1234);
    chk("t4_valid_stays", cap_bus.cap_valid, 2'b11);
    cap_bus.cap_ack = 2'b10;
    cyc();
    chk("t4_ack_clears", cap_bus.cap_valid, 2'b01);
    cyc();
    cap_bus.cap_ack = 2'b00;
    chk("t4_ack_idle_noop", cap_bus.cap_valid, 2'b01);
    chk("t4_overrun_sticky", cap_bus.overrun, 2'b10);

    // 5. full wrap, then tick while carry pending
    do_load(16'hFFFF);
    do_tick();
    chk("t5_ref", ref_value, 16'hFFFF);
    chk("t5_no_err_yet", tick_err, 1'b0);
    chk("t5_count_mid", dut.count, 16'hFF00);
    do_tick();
    chk("t5_tick_err", tick_err, 1'b1);
    chk("t5_count_after", dut.count, 16'h0001);

    // 6. reset mid-carry with a trig that would be held
    do_load(16'h00FF);
    do_tick();
    cap_bus.trig  = 2'b11;
    reset_falling = 1'b1;
    cyc();
    cap_bus.trig  = 2'b00;
    reset_falling = 1'b0;
    chk("t6_ref", ref_value, 16'h0000);
    chk("t6_ref_valid", ref_valid, 1'b0);
    chk("t6_cap_valid", cap_bus.cap_valid, 2'b00);
    chk("t6_cap_data", cap_bus.cap_data, 32'h0);
    chk("t6_overrun", cap_bus.overrun, 2'b00);
    chk("t6_tick_err", tick_err, 1'b0);
    chk("t6_count", dut.count, 16'h0000);
    cyc();
    cyc();
    cyc();
    chk("t6_no_late_cap", cap_bus.cap_valid, 2'b00);
    chk("t6_no_late_data", cap_bus.cap_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
